io_poly_dma: RTL and testbench

// Host-side streaming front end for the OpenNTT top. Loads one polynomial (N coefficients) from a

---
 rtl/io_poly_dma_pkg.sv | 29 ++
 rtl/io_skid_fifo.sv | 59 +++++
 rtl/io_poly_dma.sv | 150 +++++++++++++++
 tb/tb_io_poly_dma.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/io_poly_dma_pkg.sv
// Shared types, default geometry and the io RAM address map for the polynomial DMA front end.
// Coefficient i of slot p lands in bank i%(2*PE), row p*(N/(2*PE))+i/(2*PE).
package io_poly_dma_pkg;

  localparam int DEF_LOGQ          = 16;
  localparam int DEF_LOGN          = 4;
  localparam int DEF_PE            = 2;
  localparam int DEF_NUM_POLY_MEMS = 2;

  localparam int N  = 1 << DEF_LOGN;
  localparam int RW = $clog2(DEF_NUM_POLY_MEMS * N / 2 / DEF_PE);
  localparam int AW = $clog2(DEF_NUM_POLY_MEMS) + DEF_LOGN;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    UNLOAD
  } dma_state_t;

  // Returns {bank, row} with the row field rw bits wide.
  function automatic int unsigned io_addr_map(input int unsigned p, input int unsigned i,
                                              input int unsigned n, input int unsigned pe,
                                              input int unsigned rw);
    int unsigned banks;
    banks = 2 * pe;
    return ((i % banks) << rw) | (p * (n / banks) + i / banks);
  endfunction

endpackage

// File: rtl/io_skid_fifo.sv
// Synchronous FIFO buffering io RAM read returns ahead of the unload stream.
// Head data is presented combinationally; o_count feeds the read-credit check.
module io_skid_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 16,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: storage has no reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_poly_dma.sv
// Streams one polynomial into the NTT io RAM write port, or out of its read port, one
// coefficient per cycle; read credits bound outstanding reads to the unload FIFO space.
module io_poly_dma
  import io_poly_dma_pkg::*;
#(
  parameter  int LOGQ          = DEF_LOGQ,
  parameter  int LOGN          = DEF_LOGN,
  parameter  int PE            = DEF_PE,
  parameter  int NUM_POLY_MEMS = DEF_NUM_POLY_MEMS,
  parameter  int IO_RD_LAT     = 4,
  parameter  int FIFO_DEPTH    = 8,
  localparam int PW            = (NUM_POLY_MEMS > 1) ? $clog2(NUM_POLY_MEMS) : 1,
  localparam int ADDR_W        = $clog2(NUM_POLY_MEMS) + LOGN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [PW-1:0]     cmd_poly,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [LOGQ-1:0]   s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [LOGQ-1:0]   m_data,
  output logic              m_last,
  output logic              busy,
  output logic              io_ram_wen,
  output logic [ADDR_W-1:0] io_ram_waddr,
  output logic [LOGQ-1:0]   io_ram_wdata,
  output logic [ADDR_W-1:0] io_ram_raddr,
  input  logic [LOGQ-1:0]   io_ram_rdata
);

  localparam int            POLY_N   = 1 << LOGN;
  localparam int            ROW_W    = $clog2(NUM_POLY_MEMS * POLY_N / 2 / PE);
  localparam int            CW       = LOGN + 1;
  localparam int            FCW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(POLY_N - 1);

  if (FIFO_DEPTH < IO_RD_LAT + 1) begin : g_depth_check
    $error("io_poly_dma: FIFO_DEPTH must be at least IO_RD_LAT+1");
  end

  dma_state_t           r_state;
  logic [PW-1:0]        r_poly;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        r_pop_cnt;
  logic                 r_rd_issued;
  logic [IO_RD_LAT-1:0] r_rd_vld;
  logic                 r_wen;
  logic [ADDR_W-1:0]    r_waddr;
  logic [ADDR_W-1:0]    r_raddr;
  logic [LOGQ-1:0]      r_wdata;
  logic                 w_load_beat;
  logic                 w_issue;
  logic                 w_pop;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic [FCW-1:0]       w_fifo_count;
  int                   w_inflight;

  function automatic logic [ADDR_W-1:0] f_addr(input logic [PW-1:0] p, input logic [CW-1:0] i);
    return ADDR_W'(io_addr_map(32'(p), 32'(i), POLY_N, PE, ROW_W));
  endfunction

  assign cmd_ready    = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign s_ready      = (r_state == LOAD);
  assign w_load_beat  = s_valid && s_ready;
  assign m_valid      = !w_fifo_empty;
  assign w_pop        = m_valid && m_ready;
  assign m_last       = m_valid && (r_pop_cnt == LAST_IDX);
  assign io_ram_wen   = r_wen;
  assign io_ram_waddr = r_waddr;
  assign io_ram_wdata = r_wdata;
  assign io_ram_raddr = r_raddr;

  // NOTE: the accumulator gets a value before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    w_inflight = int'(r_rd_issued);
    for (int k = 0; k < IO_RD_LAT; k++) w_inflight += int'(r_rd_vld[k]);
  end

  // A read may issue only if its data is guaranteed a FIFO slot when it returns.
  assign w_issue = (r_state == UNLOAD) && (r_cnt < CW'(POLY_N)) &&
                   ((w_inflight + int'(w_fifo_count)) < FIFO_DEPTH);

  // NOTE: all state updates here are non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_poly      <= '0;
      r_cnt       <= '0;
      r_pop_cnt   <= '0;
      r_rd_issued <= 1'b0;
      r_rd_vld    <= '0;
      r_wen       <= 1'b0;
      r_waddr     <= '0;
      r_raddr     <= '0;
      r_wdata     <= '0;
    end else begin
      r_wen       <= w_load_beat;
      r_rd_issued <= w_issue;
      r_rd_vld    <= IO_RD_LAT'({r_rd_vld, r_rd_issued});
      if (w_load_beat) begin
        r_waddr <= f_addr(r_poly, r_cnt);
        r_wdata <= s_data;
      end
      if (w_issue) r_raddr <= f_addr(r_poly, r_cnt);
      case (r_state)
        IDLE: if (cmd_valid) begin
          r_poly    <= cmd_poly;
          r_cnt     <= '0;
          r_pop_cnt <= '0;
          r_state   <= cmd_dir ? UNLOAD : LOAD;
        end
        LOAD: if (w_load_beat) begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_IDX) r_state <= IDLE;
        end
        UNLOAD: begin
          if (w_issue) r_cnt <= r_cnt + CW'(1);
          if (w_pop) begin
            r_pop_cnt <= r_pop_cnt + CW'(1);
            if (r_pop_cnt == LAST_IDX) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  io_skid_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(LOGQ)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (r_rd_vld[IO_RD_LAT-1]),
    .i_data (io_ram_rdata),
    .i_pop  (w_pop),
    .o_data (m_data),
    .o_empty(w_fifo_empty),
    .o_full (w_fifo_full),
    .o_count(w_fifo_count)
  );

endmodule

// File: tb/tb_io_poly_dma.sv
// Directed bench for io_poly_dma: io RAM model with 4-cycle read latency, load/unload streams,
// backpressure stall, random handshakes, command-while-busy and mid-unload reset.
module tb_io_poly_dma;

  localparam int LOGQ = 16, LOGN = 4, PE = 2, NPM = 2, LAT = 4, DEPTH = 8;
  localparam int N = 16, AW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            cmd_valid = 1'b0, cmd_dir = 1'b0, cmd_poly = 1'b0;
  logic            cmd_ready, busy;
  logic            s_valid = 1'b0, s_ready;
  logic [LOGQ-1:0] s_data = '0;
  logic            m_valid, m_ready = 1'b0, m_last;
  logic [LOGQ-1:0] m_data;
  logic            io_ram_wen;
  logic [AW-1:0]   io_ram_waddr, io_ram_raddr;
  logic [LOGQ-1:0] io_ram_wdata, io_ram_rdata;

  always #5 clk = ~clk;

  io_poly_dma #(
    .LOGQ(LOGQ), .LOGN(LOGN), .PE(PE), .NUM_POLY_MEMS(NPM), .IO_RD_LAT(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir), .cmd_poly(cmd_poly),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy),
    .io_ram_wen(io_ram_wen), .io_ram_waddr(io_ram_waddr), .io_ram_wdata(io_ram_wdata),
    .io_ram_raddr(io_ram_raddr), .io_ram_rdata(io_ram_rdata)
  );

  // io RAM model: writes land on the edge after wen; reads return LAT cycles after raddr.
  logic [LOGQ-1:0] mem [32];
  logic [LOGQ-1:0] rd_pipe [LAT];
  logic [AW-1:0]   wr_addr_log [256];
  logic [LOGQ-1:0] wr_data_log [256];
  int              wr_n = 0;

  always @(posedge clk) begin
    if (io_ram_wen) begin
      mem[io_ram_waddr]  <= io_ram_wdata;
      wr_addr_log[wr_n]  <= io_ram_waddr;
      wr_data_log[wr_n]  <= io_ram_wdata;
      wr_n               <= wr_n + 1;
    end
    rd_pipe[0] <= mem[io_ram_raddr];
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign io_ram_rdata = rd_pipe[LAT-1];

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bank = i%4 in the top 2 bits, row = p*4 + i/4 in the low 3 bits.
  function automatic logic [AW-1:0] tb_map(input int p, input int i);
    return AW'(((i % 4) << 3) | (p * 4 + i / 4));
  endfunction

  task automatic send_cmd(input logic dir, input logic p);
    @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_poly  = p;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_cmd", 32'(busy), 1);
  endtask

  task automatic do_load(input int p, input int base, input bit rnd, input bit pulse, output int wr0);
    int k, cyc;
    k = 0;
    cyc = 0;
    wr0 = wr_n;
    send_cmd(1'b0, p[0]);
    while (k < N && cyc < 400) begin
      s_valid   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data    = LOGQ'(base + k);
      cmd_valid = pulse && (k == 5 || k == 6);
      cmd_dir   = 1'b1;
      check("s_ready_load", 32'(s_ready), 1);
      if (pulse) begin
        check("busy_during_load", 32'(busy), 1);
        if (k == 5) check("cmd_ready_while_busy", 32'(cmd_ready), 0);
      end
      if (s_valid) k++;
      @(negedge clk);
      cyc++;
    end
    s_valid   = 1'b0;
    cmd_valid = 1'b0;
    check("load_beats", 32'(k), N);
    check("busy_after_load", 32'(busy), 0);
    check("last_wen", 32'(io_ram_wen), 1);
    check("last_waddr", 32'(io_ram_waddr), 32'(tb_map(p, N - 1)));
    check("last_wdata", 32'(io_ram_wdata), 32'(base + N - 1));
    if (!rnd) check("load_cycles", 32'(cyc), N);
    @(negedge clk);
    check("wen_idle", 32'(io_ram_wen), 0);
    check("wen_pulses", 32'(wr_n - wr0), N);
  endtask

  task automatic do_unload(input int p, input int base, input bit rnd, input int stall_at,
                           input int stall_len, input int stop_at, input bit chk_gaps);
    int  idx, cyc, gaps, stall;
    bit  started;
    idx = 0; cyc = 0; gaps = 0; stall = 0; started = 1'b0;
    send_cmd(1'b1, p[0]);
    while (idx < stop_at && cyc < 600) begin
      if (idx == stall_at && stall < stall_len) begin
        m_ready = 1'b0;
        stall++;
        if (stall == stall_len) begin
          check("stall_credit_raddr", 32'(io_ram_raddr), 32'(tb_map(p, stall_at + DEPTH - 1)));
          check("stall_m_valid", 32'(m_valid), 1);
        end
      end else begin
        m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (m_valid) begin
        started = 1'b1;
        check("m_data", 32'(m_data), 32'(base + idx));
        check("m_last", 32'(m_last), 32'(idx == N - 1));
        if (m_ready) idx++;
      end else if (started) begin
        gaps++;
      end
      @(negedge clk);
      cyc++;
    end
    m_ready = 1'b0;
    check("unload_beats", 32'(idx), 32'(stop_at));
    if (chk_gaps) check("unload_gaps", 32'(gaps), 0);
    if (stop_at == N) begin
      check("busy_after_unload", 32'(busy), 0);
      check("m_valid_after_unload", 32'(m_valid), 0);
    end
  endtask

  initial begin
    int wr0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_last", 32'(m_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wen", 32'(io_ram_wen), 0);
    check("rst_waddr", 32'(io_ram_waddr), 0);
    check("rst_raddr", 32'(io_ram_raddr), 0);
    check("rst_wdata", 32'(io_ram_wdata), 0);
    rst_n = 1'b1;

    // Full-rate load of slot 1, then the spot-checked beat 5 write.
    do_load(1, 'h100, 1'b0, 1'b0, wr0);
    check("beat5_waddr", 32'(wr_addr_log[wr0 + 5]), 32'h0D);
    check("beat5_wdata", 32'(wr_data_log[wr0 + 5]), 32'h105);
    check("beat0_waddr", 32'(wr_addr_log[wr0]), 32'h04);

    do_unload(1, 'h100, 1'b0, N + 1, 0, N, 1'b1);
    do_unload(1, 'h100, 1'b0, 1, 20, N, 1'b1);

    // Command pulsed while loading is ignored.
    do_load(1, 'h100, 1'b0, 1'b1, wr0);

    // Random handshakes on slot 0; RAM contents checked against the intended layout.
    do_load(0, 'h200, 1'b1, 1'b0, wr0);
    for (int i = 0; i < N; i++) check("ram_slot0", 32'(mem[tb_map(0, i)]), 32'('h200 + i));
    check("ram_slot1_kept", 32'(mem[tb_map(1, 9)]), 32'h109);
    do_unload(0, 'h200, 1'b1, N + 1, 0, N, 1'b0);

    // Reset partway through an unload, then a clean unload from index 0.
    do_unload(1, 'h100, 1'b0, N + 1, 0, 7, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_m_valid", 32'(m_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_cmd_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    do_unload(1, 'h100, 1'b0, N + 1, 0, N, 1'b1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
